// File: rtl/salu_rr_sched.sv
// Two-requester round-robin front end sharing one add/sub ALU.
// One operation in flight; operands and result are registered around the ALU.
module simple_alu #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             flag
);
  logic [WIDTH:0] sum, diff;

  // The extra top bit is the carry for add and the borrow (a<b) for sub.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign out  = sel ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
  assign flag = sel ? diff[WIDTH]     : sum[WIDTH];
endmodule

module salu_rr_sched #(
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req0_sel,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_out,
  output logic             o_rsp0_flag,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic             i_req1_sel,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_out,
  output logic             o_rsp1_flag,
  output logic             o_busy,
  output logic             o_last_grant
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             sel_q, id_q, flag_q;
  logic             winner, accept;
  logic [1:0]       req_rdy, rsp_v;
  logic [WIDTH-1:0] alu_out;
  logic             alu_flag;

  assign winner = (i_req0_valid && i_req1_valid) ? ~last_grant : i_req1_valid;
  assign accept = (state == IDLE) && (i_req0_valid || i_req1_valid);

  // Handshake outputs are gated by reset so nothing is offered while it is held low.
  always_comb begin
    req_rdy = 2'b00;
    rsp_v   = 2'b00;
    if (i_reset_n && accept) begin
      if (winner) req_rdy = 2'b10;
      else        req_rdy = 2'b01;
    end
    if (i_reset_n && state == RESP) begin
      if (id_q) rsp_v = 2'b10;
      else      rsp_v = 2'b01;
    end
  end

  simple_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .sel  (sel_q),
    .out  (alu_out),
    .flag (alu_flag)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 1'b0;
      id_q       <= 1'b0;
      res_q      <= '0;
      flag_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q        <= winner ? i_req1_a   : i_req0_a;
          b_q        <= winner ? i_req1_b   : i_req0_b;
          sel_q      <= winner ? i_req1_sel : i_req0_sel;
          id_q       <= winner;
          last_grant <= winner;
          state      <= EXEC;
        end
        EXEC: begin
          res_q  <= alu_out;
          flag_q <= alu_flag;
          state  <= RESP;
        end
        RESP: if (id_q ? i_rsp1_ready : i_rsp0_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req0_ready = req_rdy[0];
  assign o_req1_ready = req_rdy[1];
  assign o_rsp0_valid = rsp_v[0];
  assign o_rsp1_valid = rsp_v[1];
  assign o_rsp0_out   = res_q;
  assign o_rsp1_out   = res_q;
  assign o_rsp0_flag  = flag_q;
  assign o_rsp1_flag  = flag_q;
  assign o_busy       = i_reset_n && (state != IDLE);
  assign o_last_grant = last_grant;
endmodule

// File: tb/tb_salu_rr_sched.sv
// Scoreboard bench for salu_rr_sched: a negedge monitor models arbitration,
// latency and arithmetic; directed cases are followed by random traffic.
module tb_salu_rr_sched;
  localparam int W    = 9;
  localparam int MOD  = 1 << W;

  typedef struct {int out; int flag; int acc;} exp_t;

  logic         i_clk = 0;
  logic         rst_n = 0;
  logic         v[2], ps[2], rr[2];
  logic [W-1:0] pa[2], pb[2];
  logic         rdy0, rdy1, rv0, rv1, rf0, rf1, busy, lg;
  logic [W-1:0] ro0, ro1;

  int   cmp = 0, errs = 0, cyc = 0;
  int   rr_mode[2];
  logic mlast = 1'b1;
  exp_t q0[$], q1[$];
  int   acc_id[$], acc_cyc[$];

  always #5 i_clk = ~i_clk;

  salu_rr_sched #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_reset_n(rst_n),
    .i_req0_valid(v[0]), .o_req0_ready(rdy0), .i_req0_a(pa[0]), .i_req0_b(pb[0]), .i_req0_sel(ps[0]),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr[0]), .o_rsp0_out(ro0), .o_rsp0_flag(rf0),
    .i_req1_valid(v[1]), .o_req1_ready(rdy1), .i_req1_a(pa[1]), .i_req1_b(pb[1]), .i_req1_sel(ps[1]),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr[1]), .o_rsp1_out(ro1), .o_rsp1_flag(rf1),
    .o_busy(busy), .o_last_grant(lg)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input bit sel, input int c);
    exp_t m;
    int r;
    r      = sel ? a - b : a + b;
    m.out  = ((r % MOD) + MOD) % MOD;
    m.flag = sel ? int'(a < b) : int'(r > MOD - 1);
    m.acc  = c;
    return m;
  endfunction

  // Response readies: 0 = always high, 1 = random, 2 = held low.
  always @(posedge i_clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      rr[i] = (rr_mode[i] == 0) ? 1'b1 : (rr_mode[i] == 1) ? 1'($urandom) : 1'b0;
  end

  always @(negedge i_clk) begin
    logic [1:0] er, ev;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {rdy1, rdy0, rv1, rv0, busy}, 0);
      q0.delete(); q1.delete();
      mlast = 1'b1;
    end else begin
      chk("busy", busy, (q0.size() + q1.size()) != 0);
      chk("last_grant", lg, mlast);
      er = 2'b00;
      if (q0.size() + q1.size() == 0) begin
        er[0] = v[0] && (!v[1] || mlast == 1'b1);
        er[1] = v[1] && (!v[0] || mlast == 1'b0);
      end
      chk("req_ready", {rdy1, rdy0}, er);
      ev[0] = q0.size() > 0 && cyc >= q0[0].acc + 2;
      ev[1] = q1.size() > 0 && cyc >= q1[0].acc + 2;
      chk("rsp_valid", {rv1, rv0}, ev);
      if (ev[0]) begin
        chk("rsp0_out", ro0, q0[0].out);
        chk("rsp0_flag", rf0, q0[0].flag);
        if (rr[0]) void'(q0.pop_front());
      end
      if (ev[1]) begin
        chk("rsp1_out", ro1, q1[0].out);
        chk("rsp1_flag", rf1, q1[0].flag);
        if (rr[1]) void'(q1.pop_front());
      end
      if (v[0] && rdy0) begin
        q0.push_back(model(pa[0], pb[0], ps[0], cyc));
        acc_id.push_back(0); acc_cyc.push_back(cyc); mlast = 1'b0;
      end
      if (v[1] && rdy1) begin
        q1.push_back(model(pa[1], pb[1], ps[1], cyc));
        acc_id.push_back(1); acc_cyc.push_back(cyc); mlast = 1'b1;
      end
    end
  end

  task automatic drive(input int id, input int a, input int b, input bit sel);
    int t = 0;
    v[id] = 1'b1; pa[id] = W'(a); pb[id] = W'(b); ps[id] = sel;
    forever begin
      @(negedge i_clk);
      if (id == 0 ? rdy0 : rdy1) break;
      if (++t > 200) begin
        cmp++; errs++;
        $display("FAIL grant_timeout: requester %0d got no ready, required within 200 cycles", id);
        break;
      end
    end
    @(posedge i_clk); #1;
    v[id] = 1'b0; pa[id] = W'($urandom); pb[id] = W'($urandom); ps[id] = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q0.size() + q1.size() != 0) begin
      @(negedge i_clk);
      if (++t > 200) begin
        cmp++; errs++;
        $display("FAIL idle_timeout: %0d responses outstanding, required 0", q0.size() + q1.size());
        break;
      end
    end
    @(negedge i_clk);
  endtask

  initial begin
    int s;
    rr_mode[0] = 0; rr_mode[1] = 0; rr[0] = 1; rr[1] = 1;
    pa[0] = 0; pb[0] = 0; ps[0] = 0; pa[1] = 0; pb[1] = 0; ps[1] = 0;
    // 1: reset with both requesters valid
    v[0] = 1; v[1] = 1;
    repeat (3) @(negedge i_clk);
    chk("reset_last_grant", lg, 1);
    chk("reset_result", {ro0, rf0}, 0);
    @(posedge i_clk); #1; rst_n = 1;
    s = acc_id.size();
    fork drive(0, 1, 2, 0); drive(1, 3, 4, 1); join
    wait_idle();
    chk("first_grant", acc_id[s], 0);
    // 2, 3: single requester arithmetic
    drive(0, 300, 250, 0); wait_idle();
    drive(1, 5, 7, 1);     wait_idle();
    drive(1, 7, 5, 1);     wait_idle();
    drive(1, 100, 27, 0);  wait_idle();
    // 4: continuous contention
    s = acc_id.size();
    fork
      for (int k = 0; k < 4; k++) drive(0, 10 * k + 400, 3 * k + 90, k[0]);
      for (int k = 0; k < 4; k++) drive(1, 7 * k, 200 - k, ~k[0]);
    join
    wait_idle();
    for (int k = 0; k < 8; k++) begin
      chk("rr_order", acc_id[s + k], k % 2);
      if (k > 0) chk("rr_gap", acc_cyc[s + k] - acc_cyc[s + k - 1], 3);
    end
    // 5: stalled response blocks the other requester
    rr_mode[0] = 2;
    fork
      drive(0, 511, 1, 0);
      begin @(posedge i_clk); #1; drive(1, 10, 20, 0); end
    join_none
    repeat (7) @(negedge i_clk);
    chk("stall_hold_valid", rv0, 1);
    s = acc_id.size();
    rr_mode[0] = 0;
    wait fork;
    wait_idle();
    chk("after_stall_grant", acc_id[s], 1);
    // 6: reset during EXEC discards the op
    drive(1, 50, 60, 1);
    rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1; rst_n = 1;
    repeat (4) @(negedge i_clk);
    chk("post_reset_last_grant", lg, 1);
    s = acc_id.size();
    fork drive(0, 9, 9, 1); drive(1, 8, 8, 0); join
    wait_idle();
    chk("post_reset_first_grant", acc_id[s], 0);
    // random traffic with random response backpressure
    rr_mode[0] = 1; rr_mode[1] = 1;
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
        drive(0, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 1'($urandom));
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
        drive(1, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 1'($urandom));
      end
    join
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
